div_unit: RTL
=============

# div_unit

Multi-cycle signed integer divider that serves the CPU's `DIV` instruction. The control unit's division request is the initiator side of a start/done handshake, and this block is the responder. It takes operands A and B from the register-file output registers and returns the remainder on `hi` and the quotient on `lo`, which are then loaded into the HI/LO registers. It also flags divide-by-zero so the control unit can raise the exception.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request pulse; sampled only in IDLE.
- `a` in WIDTH: dividend, two's complement, sampled on the start edge.
- `b` in WIDTH: divisor, two's complement, sampled on the start edge.
- `is_unsigned` in 1: only present with `DIV_UNSIGNED_EN`; sampled on the start edge.
- `hi` out WIDTH: remainder, registered.
- `lo` out WIDTH: quotient, registered.
- `busy` out 1: high while a request is in progress.
- `done` out 1: one-cycle completion pulse.
- `div_zero` out 1: one-cycle pulse, coincident with `done`, when the divisor was 0.

## Operation
- Reset state: FSM in IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0; iteration counter 0.
- States: IDLE, RUN, FIX.
- IDLE with `start`=1 and `b`≠0:
  - Latch |a| and |b|, plus sign flags sign(a) and sign(a)^sign(b).
  - Clear the partial remainder; counter=0; go to RUN.
- IDLE with `start`=1 and `b`=0:
  - Stay in IDLE.
  - On the next edge, pulse `done` and `div_zero`.
  - `hi` and `lo` hold their previous values.
- RUN performs one restoring step per cycle:
  - Shift the {remainder, dividend} pair left by 1.
  - Trial-subtract the divisor magnitude; if the result is non-negative, keep it and shift in quotient bit 1, otherwise shift in 0.
  - After WIDTH steps (counter = WIDTH-1) go to FIX.
- FIX:
  - Negate the quotient if the signs differed.
  - Negate the remainder if the dividend was negative (truncation toward zero; the remainder takes the sign of the dividend).
  - Write `lo` and `hi`, pulse `done`, return to IDLE.
- Overflow case, 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0; no flag raised.
- `start` while not in IDLE is ignored; no queueing.
- `hi` and `lo` change only in FIX and on reset.
- `a` and `b` may change freely after the start edge.
- Reset mid-operation aborts immediately and applies the full reset state; no `done` is produced.

## Timing
- Edge E0 samples `start`.
- `busy` is high from after E0 until E(WIDTH+1); for WIDTH=32, `busy` is high for 33 cycles.
- RUN occupies edges E1..E(WIDTH).
- FIX completes at edge E(WIDTH+1); `hi`, `lo` and `done` are valid in the following cycle. For WIDTH=32, `done` is high in the cycle after E33.
- Divide-by-zero: `done` and `div_zero` are high in the cycle after E1; `busy` is high for 1 cycle.
- A new `start` is accepted in the same cycle that `done` is high, since the FSM is already in IDLE.
- `done` is never high for more than one cycle.

## Configuration
- `DIV_UNSIGNED_EN` defined:
  - Adds the `is_unsigned` port.
  - When it is sampled 1: no magnitude conversion, no sign fix in FIX, and the overflow case does not apply (serves `DIVU`).
  - Latency is identical to signed operation.
- `DIV_UNSIGNED_EN` undefined: the port is absent and all operations are signed.

## Test plan
- Basic signed divide: a=7, b=2, start -> `done` after 33 busy cycles; `lo`=3, `hi`=1, `div_zero`=0.
- Sign handling:
  - a=-7 (0xFFFFFFF9), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - a=7, b=-2 -> `lo`=0xFFFFFFFD, `hi`=1.
- Divide-by-zero: preload `hi`=1, `lo`=3 from a prior divide; then a=5, b=0 -> `done` and `div_zero` in the cycle after E1; `hi`=1 and `lo`=3 unchanged.
- Overflow and ignored start: a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. A second `start` (a=9, b=3) pulsed mid-RUN is ignored, and exactly one `done` is seen.
- Reset mid-operation: assert `reset` at cycle 10 of RUN -> next cycle `busy`=0, `hi`=`lo`=0, and no `done`. A following a=100, b=7 -> `lo`=14, `hi`=2.
- With `DIV_UNSIGNED_EN`: `is_unsigned`=1, a=0xFFFFFFFF, b=2 -> `lo`=0x7FFFFFFF, `hi`=1. The same operands with `is_unsigned`=0 -> `lo`=0, `hi`=0xFFFFFFFF.

Source files
------------

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// This is a multi-cycle restoring integer divider for the CPU DIV instruction.
// The control unit sends a start pulse. After a fixed latency the divider
// returns the remainder on hi and the quotient on lo, and pulses done for one
// cycle. A divisor of zero is reported by a div_zero pulse that coincides with
// done. In that case hi and lo keep their previous values.
//
// Signed results truncate toward zero, so the remainder takes the sign of the
// dividend. The case MIN / -1 gives quotient MIN and remainder 0 and raises
// no flag.
//
// Optional feature macro: DIV_UNSIGNED_EN
//   When this macro is defined, the block has an is_unsigned input. It is
//   sampled with start. When it is 1, the divider skips the magnitude
//   conversion and the final sign fix (DIVU). The latency does not change.
//
// Parameters
//   WIDTH        operand / result width (default 32)
// Ports
//   clock        clock, rising edge active
//   reset        synchronous, active-high reset
//   start        request pulse, accepted only while idle
//   a, b         dividend / divisor, sampled on the accepting edge
//   is_unsigned  (DIV_UNSIGNED_EN only) unsigned operation select
//   hi, lo       registered remainder / quotient
//   busy         high while a request is in progress
//   done         one-cycle completion pulse
//   div_zero     one-cycle pulse with done when the divisor was zero
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_reg;
  logic             zero_pend_reg;  // divide-by-zero seen; report on next edge
  logic [WIDTH-1:0] rem_reg;        // partial remainder
  logic [WIDTH-1:0] quo_reg;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_reg;        // divisor magnitude
  logic [CW-1:0]    cnt_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;
  logic             dz_reg;

  // Operation mode for the request being sampled.
  logic uns_op;
`ifdef DIV_UNSIGNED_EN
  assign uns_op = is_unsigned;
`else
  assign uns_op = 1'b0;
`endif

  // Operand sign handling at the start edge.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = ~uns_op & a[WIDTH-1];
    b_neg = ~uns_op & b[WIDTH-1];
    // Negating MIN gives MIN back. Read as unsigned, that is the correct
    // magnitude, so MIN / -1 needs no special case.
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One restoring step. The shifted remainder can reach 2*divisor-1, so it
  // needs one extra bit. A non-negative trial result is always below the
  // divisor, so it fits back into WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    shifted  = {rem_reg, quo_reg[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_reg};
    rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Final sign correction.
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  always_comb begin
    quo_fixed = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    rem_fixed = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      zero_pend_reg <= 1'b0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      done_reg      <= 1'b0;
      dz_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (zero_pend_reg) begin
            // A zero divisor finishes one edge after it was accepted.
            // hi and lo are left untouched.
            zero_pend_reg <= 1'b0;
            done_reg      <= 1'b1;
            dz_reg        <= 1'b1;
          end else if (start) begin
            if (b == '0) begin
              zero_pend_reg <= 1'b1;
            end else begin
              rem_reg   <= '0;
              quo_reg   <= a_mag;
              dvs_reg   <= b_mag;
              neg_q_reg <= a_neg ^ b_neg;
              neg_r_reg <= a_neg;
              cnt_reg   <= '0;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          lo_reg    <= quo_fixed;
          hi_reg    <= rem_fixed;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign busy     = (state_reg != IDLE) | zero_pend_reg;
  assign done     = done_reg;
  assign div_zero = dz_reg;

endmodule
